// File: rtl/tagged_pipe_reg.sv
// Elastic tagged-word pipeline: STAGES skid-buffered stages with valid/ready on both sides,
// enable-driven flush or stall, inverted data output and occupancy count.
module tagged_pipe_reg #(
  parameter  int unsigned TAG_W    = 4,
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned STAGES   = 2,
  parameter  int unsigned CLR_MODE = 1,
  localparam int unsigned CNT_W    = $clog2(2*STAGES+1)
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_en,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [TAG_W-1:0]  i_tag,
  input  logic [DATA_W-1:0] i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [TAG_W-1:0]  o_tag,
  output logic [DATA_W-1:0] o_data,
  output logic [DATA_W-1:0] o_data_n,
  output logic [CNT_W-1:0]  o_count
);

  localparam int unsigned W            = TAG_W + DATA_W;
  localparam bit          FLUSH_ON_DIS = (CLR_MODE != 0);

  logic [STAGES-1:0] m_vld;
  logic [STAGES-1:0] s_vld;
  logic [W-1:0]      m_word [STAGES];
  logic [W-1:0]      s_word [STAGES];

  logic [STAGES-1:0] stg_rdy;
  logic [STAGES-1:0] up_vld;
  logic [STAGES-1:0] dn_rdy;
  logic [STAGES-1:0] up_fire;
  logic [STAGES-1:0] dn_fire;
  logic [W-1:0]      up_word [STAGES];

  logic in_fire;
  logic out_fire;

  // A stage can take a word whenever its skid slot is free; this comes straight
  // from a flop, so i_ready never reaches o_ready combinationally.
  assign stg_rdy = ~s_vld;
  assign up_fire = up_vld & stg_rdy;
  assign dn_fire = m_vld & dn_rdy;

  for (genvar g = 0; g < STAGES; g++) begin : g_link
    if (g == 0) begin : g_head
      assign up_vld[g]  = i_valid;
      assign up_word[g] = {i_tag, i_data};
    end else begin : g_mid
      assign up_vld[g]  = m_vld[g-1];
      assign up_word[g] = m_word[g-1];
    end
    if (g == STAGES-1) begin : g_tail
      assign dn_rdy[g] = i_ready;
    end else begin : g_body
      assign dn_rdy[g] = stg_rdy[g+1];
    end
  end

  assign o_ready  = stg_rdy[0] & i_en;
  assign o_valid  = m_vld[STAGES-1] & i_en;
  assign {o_tag, o_data} = m_word[STAGES-1];
  assign o_data_n = ~o_data;

  assign in_fire  = i_valid & o_ready;
  assign out_fire = o_valid & i_ready;

  // Main slot refills from skid first, so a parked word always leaves ahead of a new one.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        m_vld[k]  <= 1'b0;
        s_vld[k]  <= 1'b0;
        m_word[k] <= '0;
        s_word[k] <= '0;
      end
    end else if (i_en) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (dn_fire[k] || !m_vld[k]) begin
          if (s_vld[k]) begin
            m_word[k] <= s_word[k];
            m_vld[k]  <= 1'b1;
            s_vld[k]  <= 1'b0;
          end else begin
            m_vld[k] <= up_fire[k];
            if (up_fire[k]) begin
              m_word[k] <= up_word[k];
            end
          end
        end else if (up_fire[k]) begin
          s_word[k] <= up_word[k];
          s_vld[k]  <= 1'b1;
        end
      end
    end else if (FLUSH_ON_DIS) begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        m_vld[k]  <= 1'b0;
        s_vld[k]  <= 1'b0;
        m_word[k] <= '0;
        s_word[k] <= '0;
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_count <= '0;
    end else if (!i_en && FLUSH_ON_DIS) begin
      o_count <= '0;
    end else begin
      o_count <= o_count + CNT_W'(in_fire) - CNT_W'(out_fire);
    end
  end

endmodule

// File: tb/tb_tagged_pipe_reg.sv
// Scoreboard bench for tagged_pipe_reg: four configurations (depth 2 flush/hold, depth 1, depth 8),
// a driver that queues expected words and a monitor that checks every output transfer.
module tb_tagged_pipe_reg;

  logic       clk;
  logic       rst_n;
  logic [3:0] tag;
  logic [7:0] data;
  logic       en   [4];
  logic       vld  [4];
  logic       rdy  [4];
  logic       ordy [4];
  logic       ovld [4];
  logic [3:0] otag [4];
  logic [7:0] odata[4];
  logic [7:0] odn  [4];
  logic [4:0] cnt  [4];
  logic [2:0] c0, c1;
  logic [1:0] c2;
  logic [4:0] c3;

  int checks = 0;
  int errors = 0;
  int sel    = 0;
  logic [11:0] q[$];

  assign cnt[0] = {2'b00, c0};
  assign cnt[1] = {2'b00, c1};
  assign cnt[2] = {3'b000, c2};
  assign cnt[3] = c3;

  tagged_pipe_reg #(.TAG_W(4), .DATA_W(8), .STAGES(2), .CLR_MODE(1)) u_s2_clr (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en[0]), .i_valid(vld[0]), .o_ready(ordy[0]),
    .i_tag(tag), .i_data(data), .o_valid(ovld[0]), .i_ready(rdy[0]), .o_tag(otag[0]),
    .o_data(odata[0]), .o_data_n(odn[0]), .o_count(c0));

  tagged_pipe_reg #(.TAG_W(4), .DATA_W(8), .STAGES(2), .CLR_MODE(0)) u_s2_hold (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en[1]), .i_valid(vld[1]), .o_ready(ordy[1]),
    .i_tag(tag), .i_data(data), .o_valid(ovld[1]), .i_ready(rdy[1]), .o_tag(otag[1]),
    .o_data(odata[1]), .o_data_n(odn[1]), .o_count(c1));

  tagged_pipe_reg #(.TAG_W(4), .DATA_W(8), .STAGES(1), .CLR_MODE(1)) u_s1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en[2]), .i_valid(vld[2]), .o_ready(ordy[2]),
    .i_tag(tag), .i_data(data), .o_valid(ovld[2]), .i_ready(rdy[2]), .o_tag(otag[2]),
    .o_data(odata[2]), .o_data_n(odn[2]), .o_count(c2));

  tagged_pipe_reg #(.TAG_W(4), .DATA_W(8), .STAGES(8), .CLR_MODE(1)) u_s8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_en(en[3]), .i_valid(vld[3]), .o_ready(ordy[3]),
    .i_tag(tag), .i_data(data), .o_valid(ovld[3]), .i_ready(rdy[3]), .o_tag(otag[3]),
    .o_data(odata[3]), .o_data_n(odn[3]), .o_count(c3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input int k, input logic [3:0] t, input logic [7:0] d, input bit acc);
    tag    = t;
    data   = d;
    vld[k] = 1'b1;
    if (acc) begin
      chk("in_ready", 32'(ordy[k]), 1);
      q.push_back({t, d});
    end
    tick();
    vld[k] = 1'b0;
  endtask

  // Monitor: output transfers complete at the next rising edge, so sample on the falling edge.
  always @(negedge clk) begin
    logic [7:0]  inv;
    logic [11:0] e;
    if (rst_n && ovld[sel]) begin
      inv = ~odata[sel];
      chk("data_n", 32'(odn[sel]), 32'(inv));
      if (rdy[sel]) begin
        if (q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL out_word actual=%0h expected=none", {otag[sel], odata[sel]});
        end else begin
          e = q.pop_front();
          chk("out_word", 32'({otag[sel], odata[sel]}), 32'(e));
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    tag   = '0;
    data  = '0;
    for (int k = 0; k < 4; k++) begin
      en[k]  = 1'b1;
      vld[k] = 1'b0;
      rdy[k] = 1'b0;
    end
    tick();
    tick();
    chk("rst_valid", 32'(ovld[0]), 0);
    chk("rst_count", 32'(cnt[0]), 0);
    chk("rst_tag", 32'(otag[0]), 0);
    chk("rst_data", 32'(odata[0]), 0);
    chk("rst_data_n", 32'(odn[0]), 'hFF);
    chk("rst_ready", 32'(ordy[0]), 1);
    rst_n = 1'b1;
    tick();

    // mid-operation asynchronous reset
    sel = 0;
    for (int i = 0; i < 3; i++) push(0, 4'(1 + i), 8'(8'hA1 + i), 1'b1);
    chk("pre_rst_count", 32'(cnt[0]), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(ovld[0]), 0);
    chk("arst_count", 32'(cnt[0]), 0);
    chk("arst_data", 32'(odata[0]), 0);
    chk("arst_data_n", 32'(odn[0]), 'hFF);
    q.delete();
    tick();
    rst_n = 1'b1;
    chk("arst_ready", 32'(ordy[0]), 1);
    tick();

    // streaming, one word per cycle
    rdy[0] = 1'b1;
    for (int i = 0; i < 8; i++) begin
      push(0, 4'(1 + i), 8'(8'h10 + i), 1'b1);
      if (i == 0) begin
        chk("lat_valid0", 32'(ovld[0]), 0);
        chk("stream_cnt0", 32'(cnt[0]), 1);
      end else begin
        chk("stream_cnt", 32'(cnt[0]), 2);
      end
      if (i == 1) begin
        chk("lat_valid1", 32'(ovld[0]), 1);
        chk("lat_tag1", 32'(otag[0]), 1);
      end
    end
    repeat (3) tick();
    chk("stream_drain_cnt", 32'(cnt[0]), 0);
    chk("stream_q_empty", 32'(q.size()), 0);

    // backpressure to full, then release
    rdy[0] = 1'b0;
    for (int i = 0; i < 4; i++) push(0, 4'(9 + i), 8'(8'h40 + i), 1'b1);
    chk("full_cnt", 32'(cnt[0]), 4);
    chk("full_ready", 32'(ordy[0]), 0);
    push(0, 4'hF, 8'hFF, 1'b0);
    chk("full_reject_cnt", 32'(cnt[0]), 4);
    rdy[0] = 1'b1;
    tick();
    chk("ready_after_pop", 32'(ordy[0]), 0);
    chk("cnt_after_pop", 32'(cnt[0]), 3);
    tick();
    chk("ready_next_edge", 32'(ordy[0]), 1);
    chk("cnt_next_edge", 32'(cnt[0]), 2);
    repeat (3) tick();
    chk("bp_drain_cnt", 32'(cnt[0]), 0);
    chk("bp_q_empty", 32'(q.size()), 0);

    // flush with a word presented during the flush cycle
    rdy[0] = 1'b0;
    for (int i = 0; i < 3; i++) push(0, 4'(2 + i), 8'(8'h50 + i), 1'b1);
    chk("pre_flush_cnt", 32'(cnt[0]), 3);
    en[0]  = 1'b0;
    vld[0] = 1'b1;
    tag    = 4'hA;
    data   = 8'hAA;
    #1;
    chk("flush_ready", 32'(ordy[0]), 0);
    chk("flush_valid_forced", 32'(ovld[0]), 0);
    q.delete();
    tick();
    vld[0] = 1'b0;
    chk("flush_valid", 32'(ovld[0]), 0);
    chk("flush_cnt", 32'(cnt[0]), 0);
    chk("flush_tag", 32'(otag[0]), 0);
    chk("flush_data", 32'(odata[0]), 0);
    en[0]  = 1'b1;
    rdy[0] = 1'b1;
    repeat (3) tick();
    chk("flush_stays_empty", 32'(ovld[0]), 0);
    chk("flush_cnt_after", 32'(cnt[0]), 0);

    // hold mode stall
    sel    = 1;
    rdy[1] = 1'b0;
    for (int i = 0; i < 3; i++) push(1, 4'(5 + i), 8'(8'h60 + i), 1'b1);
    chk("pre_hold_cnt", 32'(cnt[1]), 3);
    en[1]  = 1'b0;
    rdy[1] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("hold_cnt", 32'(cnt[1]), 3);
      chk("hold_valid", 32'(ovld[1]), 0);
      chk("hold_ready", 32'(ordy[1]), 0);
    end
    en[1] = 1'b1;
    repeat (4) tick();
    chk("hold_drain_cnt", 32'(cnt[1]), 0);
    chk("hold_q_empty", 32'(q.size()), 0);

    // simultaneous push/pop at count 3, depth 2
    sel    = 0;
    rdy[0] = 1'b0;
    for (int i = 0; i < 3; i++) push(0, 4'(3 + i), 8'(8'h70 + i), 1'b1);
    rdy[0] = 1'b1;
    push(0, 4'h6, 8'h73, 1'b1);
    chk("simul_cnt_s2", 32'(cnt[0]), 3);
    repeat (4) tick();
    chk("simul_drain_s2", 32'(cnt[0]), 0);
    chk("simul_q_s2", 32'(q.size()), 0);

    // depth 1: full at 2, simultaneous push/pop, empty boundary
    sel    = 2;
    rdy[2] = 1'b0;
    for (int i = 0; i < 2; i++) push(2, 4'(7 + i), 8'(8'h80 + i), 1'b1);
    chk("s1_full_cnt", 32'(cnt[2]), 2);
    chk("s1_full_ready", 32'(ordy[2]), 0);
    push(2, 4'hE, 8'hEE, 1'b0);
    chk("s1_reject_cnt", 32'(cnt[2]), 2);
    rdy[2] = 1'b1;
    tick();
    chk("s1_pop_cnt", 32'(cnt[2]), 1);
    chk("s1_pop_ready", 32'(ordy[2]), 1);
    push(2, 4'h9, 8'h82, 1'b1);
    chk("s1_simul_cnt", 32'(cnt[2]), 1);
    repeat (3) tick();
    chk("s1_drain_cnt", 32'(cnt[2]), 0);
    push(2, 4'hB, 8'h83, 1'b1);
    chk("s1_empty_push_cnt", 32'(cnt[2]), 1);
    tick();
    chk("s1_final_cnt", 32'(cnt[2]), 0);
    chk("s1_q_empty", 32'(q.size()), 0);

    // depth 8: fill to 16, reject, drain in order
    sel    = 3;
    rdy[3] = 1'b0;
    for (int i = 0; i < 16; i++) push(3, 4'(i), 8'(8'hC0 + i), 1'b1);
    chk("s8_full_cnt", 32'(cnt[3]), 16);
    chk("s8_full_ready", 32'(ordy[3]), 0);
    push(3, 4'hD, 8'hDD, 1'b0);
    chk("s8_reject_cnt", 32'(cnt[3]), 16);
    rdy[3] = 1'b1;
    repeat (40) tick();
    chk("s8_drain_cnt", 32'(cnt[3]), 0);
    chk("s8_q_empty", 32'(q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
